// File: rtl/pc_gen_unit_if.sv
// Fetch/decode PC-generation bus: redirect controls and operands in, fetch PC and branch arithmetic out.
interface pc_gen_unit_if #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16
);
  logic              stall_f;
  logic              branch_d;
  logic              jump_d;
  logic [IMM_W-1:0]  imm_d;
  logic [ADDR_W-1:0] pcplus_d;
  logic [ADDR_W-1:0] jump_target_d;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] pcplus_f;
  logic [ADDR_W-1:0] signimm_d;
  logic [ADDR_W-1:0] pcbranch_d;
  logic              redirect_f;
  logic              pending_o;
  logic              misalign_f;

  modport master (
    output stall_f, branch_d, jump_d, imm_d, pcplus_d, jump_target_d,
    input  pc_f, pcplus_f, signimm_d, pcbranch_d, redirect_f, pending_o, misalign_f
  );

  modport slave (
    input  stall_f, branch_d, jump_d, imm_d, pcplus_d, jump_target_d,
    output pc_f, pcplus_f, signimm_d, pcbranch_d, redirect_f, pending_o, misalign_f
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch PC register with sequential/branch/jump select; 1-cycle redirect latency, one-slot redirect buffer.
// Stall holds the PC and parks a redirect until release. PC_ALIGN_CHECK_EN enables misaligned-target rejection.
module pc_gen_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              IMM_W    = 16,
  parameter int              STEP     = 4,
  parameter int              SHIFT    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_gen_unit_if.slave bus
);

  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << SHIFT) - 64'd1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_tgt_q;
  logic              pend_q;
  logic              misalign_q;
  logic [ADDR_W-1:0] pcplus;
  logic [ADDR_W-1:0] signimm;
  logic [ADDR_W-1:0] pcbranch;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;
  logic              req;
  logic              bad_tgt;
  logic              redirect;

  always_comb begin
    pcplus   = pc_q + STEP_V;
    signimm  = {{(ADDR_W-IMM_W){bus.imm_d[IMM_W-1]}}, bus.imm_d};
    pcbranch = (signimm << SHIFT) + bus.pcplus_d;
    req      = bus.jump_d | bus.branch_d;
    target   = bus.jump_d ? bus.jump_target_d : pcbranch;
`ifdef PC_ALIGN_CHECK_EN
    bad_tgt  = req && ((target & ALIGN_MASK) != '0);
`else
    bad_tgt  = 1'b0;
`endif
    // A rejected target falls through to sequential, not to an older pending entry.
    redirect = !bus.stall_f && ((req && !bad_tgt) || (!req && pend_q));
    next_pc  = pcplus;
    if (redirect) begin
      next_pc = req ? target : pend_tgt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else if (bus.stall_f) begin
      if (req && bad_tgt) begin
        pend_q <= 1'b0;
      end else if (req) begin
        pend_q     <= 1'b1;
        pend_tgt_q <= target;
      end
    end else begin
      pc_q   <= next_pc;
      pend_q <= 1'b0;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bad_tgt;
    end
  end
`else
  assign misalign_q = 1'b0;
`endif

  assign bus.pc_f       = pc_q;
  assign bus.pcplus_f   = pcplus;
  assign bus.signimm_d  = signimm;
  assign bus.pcbranch_d = pcbranch;
  assign bus.redirect_f = redirect;
  assign bus.pending_o  = pend_q;
  assign bus.misalign_f = misalign_q;

endmodule
